// File: rtl/gpu_pkg.sv
// Shared GPU write-path types: default bus widths, write record, scheduler states.
package gpu_pkg;
  localparam int unsigned GPU_ADDR_WIDTH = 24;
  localparam int unsigned GPU_DATA_WIDTH = 32;

  typedef struct packed {
    logic [GPU_ADDR_WIDTH-1:0] waddr;
    logic [GPU_DATA_WIDTH-1:0] wdata;
  } gpu_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } sched_state_e;
endpackage

// File: rtl/gpu_write_scheduler_if.sv
// Write bus into and out of the scheduler; the producer uses master, the scheduler slave.
interface gpu_write_scheduler_if
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = GPU_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] in_waddr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  in_wen;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] out_waddr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_wen;

  modport master (
    output in_waddr, in_wdata, in_wen,
    input  in_ready, out_waddr, out_wdata, out_wen
  );

  modport slave (
    input  in_waddr, in_wdata, in_wen,
    output in_ready, out_waddr, out_wdata, out_wen
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, combinational head read; push ignored when full, pop ignored when empty.
// Pointers carry one wrap bit so full/empty fall out of a plain compare.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/gpu_write_scheduler.sv
// Queues cluster writes and releases them immediately or only during vblank; push->out_wen 2 cycles.
// in_ready = !full is advisory: writes arriving while full are dropped and flagged in overflow.
module gpu_write_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = GPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = GPU_DATA_WIDTH,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FRAME_WIDTH = 16,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   defer_en,
  input  logic                   vblank,
  input  logic                   clr_overflow,
  gpu_write_scheduler_if.slave   bus,
  output logic [LW-1:0]          fifo_level,
  output logic                   overflow,
  output logic [FRAME_WIDTH-1:0] frame_count
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t       push_entry;
  entry_t       head;
  logic         full;
  logic         empty;
  logic         pop_en;
  logic         pop_fire;
  logic         drop;
  logic         vblank_q;
  logic         vblank_rise;
  sched_state_e state;
  sched_state_e state_nxt;

  assign push_entry = '{waddr: bus.in_waddr, wdata: bus.in_wdata};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_wen),
    .din   (push_entry),
    .pop   (pop_en),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bus.in_ready = !full;
  assign drop         = bus.in_wen && full;
  assign vblank_rise  = vblank && !vblank_q;
  assign pop_fire     = pop_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Drain is only armed by a vblank rising edge, so a frame already in blanking is skipped.
  always_comb begin
    state_nxt = state;
    pop_en    = 1'b0;
    case (state)
      IDLE: begin
        pop_en = !empty;
        if (defer_en) state_nxt = WAIT;
      end
      WAIT: begin
        if (!defer_en) begin
          state_nxt = IDLE;
        end else if (vblank_rise) begin
          pop_en    = !empty;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pop_en = !empty && vblank;
        if (!defer_en)             state_nxt = IDLE;
        else if (empty || !vblank) state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_q      <= 1'b0;
      frame_count   <= '0;
      overflow      <= 1'b0;
      bus.out_wen   <= 1'b0;
      bus.out_waddr <= '0;
      bus.out_wdata <= '0;
    end else begin
      vblank_q    <= vblank;
      bus.out_wen <= pop_fire;
      if (vblank_rise)       frame_count <= frame_count + FRAME_WIDTH'(1);
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      if (pop_fire) begin
        bus.out_waddr <= head.waddr;
        bus.out_wdata <= head.wdata;
      end
    end
  end
endmodule

// File: tb/tb_gpu_write_scheduler.sv
// Directed bench for gpu_write_scheduler: immediate/deferred release, full/overflow, reset mid-drain.
module tb_gpu_write_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        defer_en;
  logic        vblank;
  logic        clr_overflow;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] frame_count;
  int          total = 0;
  int          passed = 0;

  gpu_write_scheduler_if bus ();

  gpu_write_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .defer_en     (defer_en),
    .vblank       (vblank),
    .clr_overflow (clr_overflow),
    .bus          (bus.slave),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_push(input logic [23:0] a, input logic [31:0] d);
    bus.in_waddr = a;
    bus.in_wdata = d;
    bus.in_wen   = 1'b1;
  endtask

  initial begin
    rst = 1'b1; defer_en = 1'b0; vblank = 1'b0; clr_overflow = 1'b0;
    bus.in_waddr = '0; bus.in_wdata = '0; bus.in_wen = 1'b0;
    tick();
    tick();
    chk("rst_out_wen", 64'(bus.out_wen), 64'd0);
    chk("rst_out_waddr", 64'(bus.out_waddr), 64'd0);
    chk("rst_out_wdata", 64'(bus.out_wdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame", 64'(frame_count), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    tick();

    // Immediate mode: push in cycle N, out_wen in cycle N+2 only.
    set_push(24'h000010, 32'h00000ABC);
    tick();
    bus.in_wen = 1'b0;
    chk("imm_n1_wen", 64'(bus.out_wen), 64'd0);
    chk("imm_n1_level", 64'(fifo_level), 64'd1);
    tick();
    chk("imm_n2_wen", 64'(bus.out_wen), 64'd1);
    chk("imm_n2_addr", 64'(bus.out_waddr), 64'h10);
    chk("imm_n2_data", 64'(bus.out_wdata), 64'hABC);
    chk("imm_n2_level", 64'(fifo_level), 64'd0);
    tick();
    chk("imm_n3_wen", 64'(bus.out_wen), 64'd0);
    chk("imm_hold_addr", 64'(bus.out_waddr), 64'h10);

    // Deferred: 5 writes held while vblank low, released in order on the rise.
    defer_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      set_push(24'h000100 + 24'(i), 32'h00005000 + 32'(i));
      tick();
    end
    bus.in_wen = 1'b0;
    tick();
    chk("def_held_wen", 64'(bus.out_wen), 64'd0);
    chk("def_held_level", 64'(fifo_level), 64'd5);
    vblank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 9) vblank = 1'b0;
      chk("def_burst_wen", 64'(bus.out_wen), 64'(k < 5));
      if (k < 5) begin
        chk("def_burst_addr", 64'(bus.out_waddr), 64'h100 + 64'(k));
        chk("def_burst_data", 64'(bus.out_wdata), 64'h5000 + 64'(k));
      end
    end
    chk("def_frame", 64'(frame_count), 64'd1);
    chk("def_level", 64'(fifo_level), 64'd0);

    // Fill to DEPTH, then three drops; contents must stay intact.
    tick();
    for (int i = 0; i < 16; i++) begin
      set_push(24'h000200 + 24'(i), 32'h00006000 + 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_push(24'h000BAD, 32'h0000DEAD);
      tick();
    end
    bus.in_wen = 1'b0;
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_overflow", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    set_push(24'h000BAD, 32'h0000DEAD);
    tick();
    bus.in_wen = 1'b0;
    clr_overflow = 1'b0;
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Two 4-cycle vblank windows release exactly 4 entries each.
    for (int w = 0; w < 2; w++) begin
      vblank = 1'b1;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (k == 3) vblank = 1'b0;
        chk("win_wen", 64'(bus.out_wen), 64'(k < 4));
        if (k < 4) chk("win_addr", 64'(bus.out_waddr), 64'h200 + 64'(4 * w + k));
      end
      chk("win_level", 64'(fifo_level), 64'(12 - 4 * w));
      chk("win_frame", 64'(frame_count), 64'(2 + w));
      tick();
    end

    // Reset in the middle of a drain burst.
    vblank = 1'b1;
    tick();
    chk("rd_first_addr", 64'(bus.out_waddr), 64'h208);
    tick();
    chk("rd_second_addr", 64'(bus.out_waddr), 64'h209);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vblank = 1'b0;
    chk("rd_wen", 64'(bus.out_wen), 64'd0);
    chk("rd_addr", 64'(bus.out_waddr), 64'd0);
    chk("rd_level", 64'(fifo_level), 64'd0);
    chk("rd_frame", 64'(frame_count), 64'd0);
    chk("rd_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rd_no_stale", 64'(bus.out_wen), 64'd0);
    end

    // Six queued in defer mode; dropping defer_en releases them back-to-back.
    for (int i = 0; i < 6; i++) begin
      set_push(24'h000300 + 24'(i), 32'h00007000 + 32'(i));
      tick();
    end
    bus.in_wen = 1'b0;
    tick();
    chk("rel_held_level", 64'(fifo_level), 64'd6);
    chk("rel_held_wen", 64'(bus.out_wen), 64'd0);
    defer_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rel_wen", 64'(bus.out_wen), 64'(k >= 1 && k <= 6));
      if (k >= 1 && k <= 6) chk("rel_addr", 64'(bus.out_waddr), 64'h300 + 64'(k - 1));
    end
    chk("rel_level", 64'(fifo_level), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
